// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_e;

  localparam int DM_WAIT_CYCLES = 1;
  localparam int DM_ADDR_W      = 8;

  // True when every byte-address bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with byte write enables, one enabled read port and one
// free-running debug read port; both reads return the pre-write contents.
module dmem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (rd_en) rd_data <= mem[addr];
    dbg_data <= mem[dbg_addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM stage: latches a request, waits
// WAIT_CYCLES+1 ACCESS cycles, performs the RAM operation and pulses dm_ready.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = DM_ADDR_W,
  parameter int WAIT_CYCLES = DM_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_err,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data,
  output dm_state_e   dbg_state
);

  // Handshake: dm_req is sampled only in IDLE; the request is accepted on that
  // edge. dm_ready is a one-cycle pulse (with dm_err); the initiator drops dm_req
  // the cycle after dm_ready, otherwise a held dm_req is a new request.

  dm_state_e         state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] req_word;
  logic [3:0]        req_wen;
  logic [31:0]       req_wdata;
  logic              req_oor;
  logic              accept, commit;
  logic              rdata_ok, test_ok;
  logic [3:0]        ram_we;
  logic              ram_rd_en;
  logic [31:0]       ram_rd_data, ram_dbg_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{dm_addr[1:0], test_addr[1:0]};
  assign dbg_state        = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dm_req) begin
          accept    = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= 4'd0;
      req_word  <= '0;
      req_wen   <= 4'd0;
      req_wdata <= 32'd0;
      req_oor   <= 1'b0;
    end else if (accept) begin
      cnt       <= 4'(WAIT_CYCLES);
      req_word  <= dm_addr[ADDR_W+1:2];
      req_wen   <= dm_wen;
      req_wdata <= dm_wdata;
      req_oor   <= !addr_in_range(dm_addr, ADDR_W);
    end else if (state == ST_ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The RAM output register is the read-data register; rdata_ok / test_ok
  // force zero after reset and for out-of-range addresses.
  assign ram_we    = (commit && !req_oor) ? req_wen : 4'b0000;
  assign ram_rd_en = commit && (req_wen == 4'b0000) && !req_oor;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dm_ready <= 1'b0;
      dm_err   <= 1'b0;
      rdata_ok <= 1'b0;
      test_ok  <= 1'b0;
    end else begin
      dm_ready <= commit;
      dm_err   <= commit && req_oor;
      if (commit && req_wen == 4'b0000) rdata_ok <= !req_oor;
      test_ok  <= addr_in_range(test_addr, ADDR_W);
    end
  end

  assign dm_rdata  = rdata_ok ? ram_rd_data  : 32'd0;
  assign test_data = test_ok  ? ram_dbg_data : 32'd0;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk      (clk),
    .we       (ram_we),
    .addr     (req_word),
    .wdata    (req_wdata),
    .rd_en    (ram_rd_en),
    .rd_data  (ram_rd_data),
    .dbg_addr (test_addr[ADDR_W+1:2]),
    .dbg_data (ram_dbg_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a request-level model predicts every output each
// cycle, plus directed literal checks from the test plan.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int W = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic        dm_req = 1'b0;
  logic [31:0] dm_addr = 32'd0, dm_wdata = 32'd0, test_addr = 32'h0000_0800;
  logic [3:0]  dm_wen = 4'd0;
  logic [31:0] dm_rdata, test_data;
  logic        dm_ready, dm_err;
  dm_state_e   dbg_state;

  logic        r0_req = 1'b0;
  logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0, r0_test_addr = 32'd0;
  logic [3:0]  r0_wen = 4'd0;
  logic [31:0] r0_rdata, r0_test_data;
  logic        r0_ready, r0_err;
  dm_state_e   r0_state;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .resetn(resetn), .dm_req(dm_req), .dm_addr(dm_addr), .dm_wen(dm_wen),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_err(dm_err),
    .test_addr(test_addr), .test_data(test_data), .dbg_state(dbg_state)
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .dm_req(r0_req), .dm_addr(r0_addr), .dm_wen(r0_wen),
    .dm_wdata(r0_wdata), .dm_rdata(r0_rdata), .dm_ready(r0_ready), .dm_err(r0_err),
    .test_addr(r0_test_addr), .test_data(r0_test_data), .dbg_state(r0_state)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [256];
  bit          mem_known [256];
  int          cyc = 0;
  bit          pend_valid = 1'b0;
  int          pend_commit = 0;
  logic [31:0] pend_addr, pend_wdata;
  logic [3:0]  pend_wen;
  logic        exp_ready = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'd0, exp_test = 32'd0;
  bit          exp_test_known = 1'b1;
  logic [31:0] exp_q [$];

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid     = 1'b0;
      exp_ready      = 1'b0;
      exp_err        = 1'b0;
      exp_rdata      = 32'd0;
      exp_test       = 32'd0;
      exp_test_known = 1'b1;
    end else begin
      logic [31:0] mask;
      cyc++;
      if (test_addr < 32'd1024) begin
        exp_test       = mem_m[widx(test_addr)];
        exp_test_known = mem_known[widx(test_addr)];
      end else begin
        exp_test       = 32'd0;
        exp_test_known = 1'b1;
      end
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      if (pend_valid && cyc == pend_commit) begin
        pend_valid = 1'b0;
        exp_ready  = 1'b1;
        exp_err    = (pend_addr >= 32'd1024);
        if (pend_wen == 4'd0) begin
          exp_rdata = exp_err ? 32'd0 : mem_m[widx(pend_addr)];
          exp_q.push_back(exp_rdata);
        end else if (!exp_err) begin
          mask = {{8{pend_wen[3]}}, {8{pend_wen[2]}}, {8{pend_wen[1]}}, {8{pend_wen[0]}}};
          mem_m[widx(pend_addr)] = (mem_m[widx(pend_addr)] & ~mask) | (pend_wdata & mask);
          if (pend_wen == 4'hF) mem_known[widx(pend_addr)] = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dm_ready", {31'd0, dm_ready}, {31'd0, exp_ready});
      chk("dm_err",   {31'd0, dm_err},   {31'd0, exp_err});
      chk("dm_rdata", dm_rdata, exp_rdata);
      if (exp_test_known) chk("test_data", test_data, exp_test);
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the edge ending RESP.
  task automatic do_req(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output logic [31:0] td,
                        output int lat);
    bit got;
    dm_addr = addr; dm_wen = wen; dm_wdata = wdata; dm_req = 1'b1;
    pend_addr = addr; pend_wen = wen; pend_wdata = wdata;
    pend_commit = cyc + W + 2; pend_valid = 1'b1;
    @(posedge clk); #1;
    dm_req = 1'b0;
    dm_addr = $urandom(); dm_wen = 4'($urandom_range(0, 15)); dm_wdata = $urandom();
    got = 1'b0; lat = 0; rd = 32'd0; er = 1'b0; td = 32'd0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (dm_ready) begin
        got = 1'b1; rd = dm_rdata; er = dm_err; td = test_data;
      end
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_req0(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                         output logic [31:0] rd, output int lat, output int rdy_cyc);
    bit got;
    r0_addr = addr; r0_wen = wen; r0_wdata = wdata; r0_req = 1'b1;
    @(posedge clk); #1;
    r0_req = 1'b0;
    got = 1'b0; lat = 0; rd = 32'd0; rdy_cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (r0_ready) begin
        got = 1'b1; rd = r0_rdata; rdy_cyc = cyc;
      end
    end
    if (!got) chk("ready0_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd, td;
    logic        er;
    int          lat, c1, c2;
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 32'd0;
      mem_known[i] = 1'b0;
    end
    #1 resetn = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    do_req(32'h0000_0010, 4'hF, 32'hDEAD_BEEF, rd, er, td, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_err", {31'd0, er}, 32'd0);
    do_req(32'h0000_0010, 4'h0, 32'd0, rd, er, td, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_word", rd, 32'hDEAD_BEEF);

    do_req(32'h0000_0020, 4'hF, 32'h1122_3344, rd, er, td, lat);
    do_req(32'h0000_0020, 4'b0100, 32'h00AA_0000, rd, er, td, lat);
    do_req(32'h0000_0022, 4'h0, 32'd0, rd, er, td, lat);
    chk("byte_lane", rd, 32'h11AA_3344);

    do_req(32'h0000_0000, 4'hF, 32'h1234_5678, rd, er, td, lat);
    do_req(32'h0000_0400, 4'hF, 32'hFFFF_FFFF, rd, er, td, lat);
    chk("oor_wr_err", {31'd0, er}, 32'd1);
    do_req(32'h0000_0400, 4'h0, 32'd0, rd, er, td, lat);
    chk("oor_rd_err", {31'd0, er}, 32'd1);
    chk("oor_rd_data", rd, 32'd0);
    do_req(32'h0000_0000, 4'h0, 32'd0, rd, er, td, lat);
    chk("oor_no_alias", rd, 32'h1234_5678);

    // Abort a write of 0x55 to 0x30 while it is still in ACCESS.
    do_req(32'h0000_0030, 4'hF, 32'h0000_0000, rd, er, td, lat);
    dm_addr = 32'h0000_0030; dm_wen = 4'hF; dm_wdata = 32'h0000_0055; dm_req = 1'b1;
    pend_addr = dm_addr; pend_wen = dm_wen; pend_wdata = dm_wdata;
    pend_commit = cyc + W + 2; pend_valid = 1'b1;
    @(posedge clk); #1;
    dm_req = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_rdata", dm_rdata, 32'd0);
    chk("rst_ready", {31'd0, dm_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    do_req(32'h0000_0030, 4'h0, 32'd0, rd, er, td, lat);
    chk("rst_write_lost", rd, 32'd0);

    test_addr = 32'h0000_0010;
    @(posedge clk); #1;
    do_req(32'h0000_0010, 4'hF, 32'hCAFE_F00D, rd, er, td, lat);
    chk("dbg_old_value", td, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("dbg_new_value", test_data, 32'hCAFE_F00D);
    @(posedge clk); #1;
    do_req(32'h0000_0010, 4'h0, 32'd0, rd, er, td, lat);
    chk("rd_after_dbg", rd, 32'hCAFE_F00D);
    chk("exp_q_head", exp_q[exp_q.size()-1], 32'hCAFE_F00D);

    // Zero-wait instance: back-to-back with dm_req dropped after each ready.
    do_req0(32'h0000_0040, 4'hF, 32'h0BAD_F00D, rd, lat, c1);
    chk("w0_wr_latency", 32'(lat), 32'd2);
    do_req0(32'h0000_0040, 4'h0, 32'd0, rd, lat, c2);
    chk("w0_rd_latency", 32'(lat), 32'd2);
    chk("w0_spacing", 32'(c2 - c1), 32'd3);
    chk("w0_rd_data", rd, 32'h0BAD_F00D);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
